// File: rtl/axis_bram_writer_pkg.sv
// Shared types for the AXI-Stream to BRAM frame writer.
// Holds the capture FSM state encoding and byte-enable sizing.
package axis_bram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DROP,
    DONE
  } state_t;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/axis_bram_writer_if.sv
// AXI-Stream bundle between an upstream source and the BRAM writer.
// The writer is the slave; tready is its only driven signal.
interface axis_bram_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/axis_bram_writer.sv
// Captures one complete, frame-aligned AXI-Stream frame into BRAM on arm.
// Publishes the captured length; 0 means the full 2**ADDR_WIDTH depth.
module axis_bram_writer
  import axis_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  localparam int BW = be_width(DATA_WIDTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  arm,
  axis_bram_if.slave            s_axis,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wrdata,
  output logic [BW-1:0]         bram_we,
  output logic                  bram_en,
  output logic                  bram_clk,
  output logic [ADDR_WIDTH-1:0] frame_len,
  output logic                  done,
  output logic                  overflow,
  output logic                  busy
);

  state_t                state;
  state_t                state_n;
  logic                  in_frame;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   ptr_n;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] len_n;
  logic                  ovf_n;
  logic                  accept;
  logic                  start;

  assign s_axis.tready = !areset;
  assign bram_clk      = aclk;
  assign accept        = s_axis.tvalid && !areset;
  assign start         = accept && !in_frame;

  always_comb begin
    state_n = state;
    ptr_n   = wr_ptr;
    wr      = 1'b0;
    waddr   = wr_ptr[ADDR_WIDTH-1:0];
    len_n   = frame_len;
    ovf_n   = overflow;
    unique case (state)
      IDLE: begin
        if (arm) begin
          state_n = ARMED;
          ptr_n   = '0;
        end
      end
      ARMED: begin
        if (start) begin
          wr    = 1'b1;
          waddr = '0;
          ptr_n = (ADDR_WIDTH+1)'(1);
          if (s_axis.tlast) begin
            state_n = DONE;
            len_n   = ADDR_WIDTH'(1);
          end else begin
            state_n = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (accept) begin
          wr    = 1'b1;
          ptr_n = wr_ptr + 1'b1;
          if (s_axis.tlast) begin
            state_n = DONE;
            len_n   = ptr_n[ADDR_WIDTH-1:0];
          end else if (ptr_n[ADDR_WIDTH]) begin
            // depth exhausted mid-frame: drain the rest of it
            state_n = DROP;
            ovf_n   = 1'b1;
          end
        end
      end
      DROP: begin
        if (accept && s_axis.tlast) begin
          state_n = DONE;
          len_n   = '0;
        end
      end
      DONE: begin
        if (arm) begin
          state_n = ARMED;
          ptr_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= IDLE;
      in_frame    <= 1'b0;
      wr_ptr      <= '0;
      bram_en     <= 1'b0;
      bram_we     <= '0;
      bram_addr   <= '0;
      bram_wrdata <= '0;
      frame_len   <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state     <= state_n;
      wr_ptr    <= ptr_n;
      frame_len <= len_n;
      overflow  <= ovf_n;
      done      <= (state_n == DONE);
      busy      <= (state_n == ARMED) ||
                   (state_n == CAPTURE) ||
                   (state_n == DROP);
      bram_en   <= wr;
      bram_we   <= {BW{wr}};
      if (wr) begin
        bram_addr   <= waddr;
        bram_wrdata <= s_axis.tdata;
      end
      if (accept) in_frame <= !s_axis.tlast;
    end
  end

endmodule

// File: tb/tb_axis_bram_writer.sv
// Scoreboard bench for axis_bram_writer with a frame-level reference model.
// Small depth (ADDR_WIDTH=3) so truncation and wrap are reachable.
module tb_axis_bram_writer;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic arm = 1'b0;
  always #5 clk = ~clk;

  axis_bram_if #(.DATA_WIDTH(DW)) s_axis ();

  logic [AW-1:0]   bram_addr;
  logic [AW-1:0]   frame_len;
  logic [DW-1:0]   bram_wrdata;
  logic [DW/8-1:0] bram_we;
  logic bram_en, bram_clk, done, overflow, busy;

  axis_bram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk(clk),
    .areset(areset),
    .arm(arm),
    .s_axis(s_axis),
    .bram_addr(bram_addr),
    .bram_wrdata(bram_wrdata),
    .bram_we(bram_we),
    .bram_en(bram_en),
    .bram_clk(bram_clk),
    .frame_len(frame_len),
    .done(done),
    .overflow(overflow),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int len; bit ovf; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  // reference: 0 = not capturing, 1 = waiting for a frame start, 2 = in frame
  int mode = 0;
  bit m_in_frame = 1'b0;
  int nbeats = 0;

  task automatic model(bit a, bit v, bit l, int d);
    int m0;
    m0 = mode;
    if (v) begin
      if (mode == 1 && !m_in_frame) begin
        mode = 2;
        nbeats = 0;
      end
      if (mode == 2) begin
        if (nbeats < DEPTH) wq.push_back('{nbeats, d & 16'hFFFF});
        nbeats++;
        if (l) begin
          dq.push_back('{(nbeats > DEPTH) ? 0 : nbeats % DEPTH,
                         nbeats > DEPTH});
          mode = 0;
        end
      end
      m_in_frame = !l;
    end
    if (a && m0 == 0) mode = 1;
  endtask

  task automatic cycle(bit a, bit v, bit l, int d);
    arm = a;
    s_axis.tvalid = v;
    s_axis.tlast = l;
    s_axis.tdata = d[DW-1:0];
    if (!areset) model(a, v, l, d);
    @(posedge clk);
    #1;
  endtask

  task automatic frame(int n, int base);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, i == n - 1, base + i);
  endtask

  bit done_q = 1'b0;
  always @(negedge clk) begin
    wr_t w;
    dn_t e;
    if (bram_en) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected none",
                 bram_addr, bram_wrdata);
      end else begin
        w = wq.pop_front();
        check("wr_addr", 32'(bram_addr), w.addr);
        check("wr_data", 32'(bram_wrdata), w.data);
        check("wr_we", 32'(bram_we), 32'h3);
      end
    end else begin
      if (bram_we != '0) begin
        checks++;
        errors++;
        $display("FAIL we_idle: got %0h expected 0", bram_we);
      end
    end
    if (done && !done_q) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        e = dq.pop_front();
        check("frame_len", 32'(frame_len), e.len);
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("done_with_write", 32'(bram_en), 32'(!e.ovf));
      end
    end
    done_q = done;
  end

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    s_axis.tdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tready", 32'(s_axis.tready), 0);
    check("rst_en", 32'(bram_en), 0);
    check("rst_addr", 32'(bram_addr), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_len", 32'(frame_len), 0);
    check("rst_ovf", 32'(overflow), 0);
    areset = 1'b0;
    #1;
    check("tready_run", 32'(s_axis.tready), 1);

    cycle(1'b1, 1'b0, 1'b0, 0);
    check("busy_armed", 32'(busy), 1);
    frame(4, 'hA0);
    check("done_4", 32'(done), 1);
    check("len_4", 32'(frame_len), 4);

    cycle(1'b0, 1'b1, 1'b0, 'h10);
    cycle(1'b0, 1'b1, 1'b0, 'h11);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("done_clear_on_arm", 32'(done), 0);
    cycle(1'b0, 1'b1, 1'b1, 'h12);
    frame(2, 'h20);
    cycle(1'b0, 1'b0, 1'b0, 0);
    check("len_2", 32'(frame_len), 2);

    cycle(1'b1, 1'b0, 1'b0, 0);
    frame(1, 'h55);
    check("len_1", 32'(frame_len), 1);

    cycle(1'b1, 1'b0, 1'b0, 0);
    frame(10, 'h300);
    cycle(1'b0, 1'b0, 1'b0, 0);
    check("ovf_done", 32'(done), 1);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_len", 32'(frame_len), 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("ovf_clear_done", 32'(done), 0);
    check("ovf_clear_flag", 32'(overflow), 0);
    frame(3, 'h400);

    cycle(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 'h500 + i);
    areset = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 'h599);
    areset = 1'b0;
    mode = 0;
    m_in_frame = 1'b0;
    check("rst_mid_en", 32'(bram_en), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_busy", 32'(busy), 0);
    frame(4, 'h600);
    cycle(1'b1, 1'b0, 1'b0, 0);
    frame(2, 'h700);

    repeat (40) begin
      int n;
      n = $urandom_range(1, 11);
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 2) == 0)
          cycle($urandom_range(0, 5) == 0, 1'b0, 1'b0, 0);
        cycle($urandom_range(0, 5) == 0, 1'b1, i == n - 1, $urandom);
      end
    end

    repeat (4) cycle(1'b0, 1'b0, 1'b0, 0);
    check("wq_empty", wq.size(), 0);
    check("dq_empty", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_bram_writer.md
Name: axis_bram_writer

Overview:
AXI-Stream slave that captures one complete frame into a single-port BRAM on request. It is the upstream stage of the BRAM reader: it fills the shared BRAM and publishes the captured frame length, which drives the reader's limit input directly. Captures are frame-aligned: a capture never starts mid-frame, and upstream is never back-pressured.

Parameters:
DATA_WIDTH, 16, stream and BRAM data width in bits; must be a multiple of 8.
ADDR_WIDTH, 12, BRAM word-address width; capture depth is 2**ADDR_WIDTH words.

Ports:
aclk  in  1  clock; single clock domain.
areset  in  1  synchronous, active-high reset.
arm  in  1  single-cycle request to capture the next complete frame.
s_axis_tdata  in  DATA_WIDTH  stream data.
s_axis_tvalid  in  1  stream valid.
s_axis_tready  out  1  stream ready.
s_axis_tlast  in  1  end-of-frame marker.
bram_addr  out  ADDR_WIDTH  BRAM word address.
bram_wrdata  out  DATA_WIDTH  BRAM write data.
bram_we  out  DATA_WIDTH/8  byte write enables; all ones or all zeros.
bram_en  out  1  BRAM enable.
bram_clk  out  1  equals aclk, passed through combinationally.
frame_len  out  ADDR_WIDTH  number of captured words; 0 means full depth (2**ADDR_WIDTH).
done  out  1  a capture is complete and frame_len is valid.
overflow  out  1  the last capture was truncated at full depth.
busy  out  1  the FSM is in ARMED, CAPTURE or DROP.

Behaviour:
- Reset, active-high, synchronous, applied on the next aclk edge:
  - state=IDLE, in_frame=0, wr_ptr=0.
  - bram_en=0, bram_we=0, bram_addr=0, bram_wrdata=0.
  - frame_len=0, done=0, overflow=0, busy=0.
  - s_axis_tready=0 while areset is high.
- Reset mid-capture: the partial capture is abandoned; done stays 0 after reset; no further BRAM writes occur.
- s_axis_tready=1 at all times outside reset. Beats received in IDLE or DONE are discarded.
- in_frame tracking runs in every state:
  - set on an accepted beat with tlast=0;
  - cleared on an accepted beat with tlast=1.
- A beat is frame-start when it is accepted while in_frame=0.
- FSM states: IDLE, ARMED, CAPTURE, DROP, DONE.
  - IDLE: arm -> ARMED.
  - ARMED: a frame-start beat is written to address 0 in the same cycle's write slot. Then -> CAPTURE, or -> DONE with frame_len=1 if tlast=1. Non-start beats are discarded.
  - CAPTURE: each accepted beat is written to wr_ptr, then wr_ptr is incremented.
    - Beat with tlast -> DONE, frame_len=wr_ptr+1 (mod 2**ADDR_WIDTH).
    - The 2**ADDR_WIDTH-th beat without tlast -> DROP.
  - DROP: beats are discarded; overflow is set. The tlast beat -> DONE with frame_len=0.
  - DONE: done=1, held. arm -> ARMED; done and overflow clear on the next edge.
- arm is ignored in ARMED, CAPTURE and DROP.
- arm coinciding with an accepted beat in IDLE: the FSM enters ARMED, but that beat is not captured. The beat still updates in_frame.
- Write latency: for a beat accepted at edge N, the following are all registered and valid in cycle N+1:
  - bram_en=1, bram_we=all ones, bram_addr, bram_wrdata.
  - done and frame_len update in that same cycle N+1, coincident with the final write.
- bram_en=0 and bram_we=0 in any cycle with no write.
- wr_ptr is ADDR_WIDTH+1 bits wide, to detect full depth. bram_addr is wr_ptr[ADDR_WIDTH-1:0].
- busy=1 in ARMED, CAPTURE and DROP; registered, reflecting the current state.

Decomposition:
- Package axis_bram_pkg holds the FSM state enum (IDLE, ARMED, CAPTURE, DROP, DONE) and a function for byte-enable width (DATA_WIDTH/8).
- No sub-module: a single FSM plus a write pointer is sufficient.

Test Plan:
- Reset, then arm, then a 4-beat frame 0xA0..0xA3 with tlast on beat 4:
  - writes at addresses 0..3;
  - frame_len=4 and done=1 in the cycle of the addr-3 write.
- Arm asserted mid-frame (beats 0x10, 0x11 already accepted, tlast on 0x12), followed by a 2-beat frame 0x20, 0x21:
  - only 0x20 and 0x21 are written, at addresses 0 and 1;
  - frame_len=2.
- Single-beat frame 0x55 with tlast after arm: one write at address 0; frame_len=1; done=1.
- With ADDR_WIDTH=3, a 10-beat frame after arm:
  - 8 writes at addresses 0..7, then no writes;
  - on the tlast beat: done=1, overflow=1, frame_len=0.
- Arm while in DONE: done and overflow drop the next cycle; the next frame overwrites from address 0.
- Areset asserted during CAPTURE after 3 writes:
  - next cycle: bram_en=0, done=0, state IDLE;
  - a subsequent frame is not written until arm is asserted.
